// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;

  // Ceiling log2 for sizing counters and index fields.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width with a floor of one bit.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request strictly after 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  // Scan upward from last+1 modulo N_REQ and keep the first hit.
  always_comb begin
    pick    = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = IW'((int'(last) + k) % N_REQ);
      if (!found_s && req[cand_s]) begin
        found_s      = 1'b1;
        pick[cand_s] = 1'b1;
        idx          = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// granting bounded bursts and stalling (never dropping) on FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  input  logic                fifo_full,
  output logic [DW-1:0]       fifo_d_in,
  output logic                fifo_write
);

  localparam int IW = idx_w(N_REQ);
  localparam int BW = clog2(MAX_BURST + 1);

  state_t           state_r, state_n;
  logic [N_REQ-1:0] grant_r, grant_n;
  logic [IW-1:0]    last_r, last_n;
  logic [IW-1:0]    gidx_r, gidx_n;
  logic [BW-1:0]    bcnt_r, bcnt_n;

  logic [N_REQ-1:0] pick_s;
  logic [IW-1:0]    pick_idx_s;
  logic             req_g_s;
  logic             write_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req  (req),
    .last (last_r),
    .pick (pick_s),
    .idx  (pick_idx_s)
  );

  // State, ownership and burst counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= IW'(N_REQ - 1);
      gidx_r  <= '0;
      bcnt_r  <= '0;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      last_r  <= last_n;
      gidx_r  <= gidx_n;
      bcnt_r  <= bcnt_n;
    end
  end

  // Next-state and write-port steering; full gates the write in the same cycle.
  always_comb begin
    state_n   = state_r;
    grant_n   = grant_r;
    last_n    = last_r;
    gidx_n    = gidx_r;
    bcnt_n    = bcnt_r;
    req_g_s   = 1'b0;
    write_s   = 1'b0;
    fifo_d_in = '0;
    ack       = '0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_n = BURST;
          grant_n = pick_s;
          gidx_n  = pick_idx_s;
          bcnt_n  = '0;
        end else begin
          grant_n = '0;
        end
      end
      BURST: begin
        req_g_s   = req[gidx_r];
        write_s   = req_g_s & ~fifo_full;
        fifo_d_in = wdata[gidx_r*DW +: DW];
        ack       = write_s ? grant_r : '0;
        // A dropped request ends the burst even if nothing was written.
        if (!req_g_s || (write_s && ((bcnt_r + 1'b1) == BW'(MAX_BURST)))) begin
          state_n = IDLE;
          grant_n = '0;
          last_n  = gidx_r;
          bcnt_n  = '0;
        end else if (write_s) begin
          bcnt_n = bcnt_r + 1'b1;
        end else begin
          bcnt_n = bcnt_r;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  assign fifo_write = write_s;
  assign grant      = grant_r;
  assign busy       = (state_r == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with producer queues and a depth-8 FIFO model.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        fifo_full;
  logic [7:0]  fifo_d_in;
  logic        fifo_write;

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wdata      (wdata),
    .ack        (ack),
    .grant      (grant),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_d_in  (fifo_d_in),
    .fifo_write (fifo_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string cur_test = "";

  logic [7:0] pmem [4][16];
  int         phead [4];
  int         ptail [4];
  logic [7:0] fmem [16];
  int         fcnt;
  logic [7:0] alog [32];
  int         acnt;
  logic       fifo_mode;
  logic       full_man;
  int         viol;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h expected=%h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    pmem[i][ptail[i]] = d;
    ptail[i]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      req[i] = (phead[i] < ptail[i]);
      wdata[i*8 +: 8] = req[i] ? pmem[i][phead[i]] : 8'h00;
    end
    fifo_full = fifo_mode ? (fcnt >= 8) : full_man;
  endtask

  // Clock edge; retire the word acked before the edge.
  task automatic advance(input logic wr, input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    if (wr) begin
      for (int i = 0; i < 4; i++) if (a[i]) phead[i]++;
      alog[acnt] = d;
      acnt++;
      if (fifo_mode && fcnt < 8) begin
        fmem[fcnt] = d;
        fcnt++;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] eg, input logic ew, input logic [7:0] ed, input logic full);
    full_man = full;
    drive_inputs();
    #1;
    check_val("grant", 32'(grant), 32'(eg));
    check_val("write", 32'(fifo_write), 32'(ew));
    check_val("ack", 32'(ack), ew ? 32'(eg) : 32'h0);
    check_val("busy", 32'(busy), (eg != 4'b0000) ? 32'h1 : 32'h0);
    if (ew) check_val("d_in", 32'(fifo_d_in), 32'(ed));
    advance(fifo_write, ack, fifo_d_in);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    fcnt = 0;
    acnt = 0;
    full_man = 1'b0;
    fifo_mode = 1'b0;
    drive_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] exp6 [8];

  initial begin
    rst = 1'b1;
    fifo_mode = 1'b0;
    full_man = 1'b0;
    fcnt = 0;
    acnt = 0;
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end

    // Reset held with all requests up, then an async reset mid-burst.
    cur_test = "t1";
    for (int i = 0; i < 4; i++) push(i, 8'(8'hA0 + i));
    drive_inputs();
    #3;
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_ack", 32'(ack), 32'h0);
    check_val("rst_write", 32'(fifo_write), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    drive_inputs();
    #1;
    check_val("b_grant", 32'(grant), 32'h1);
    check_val("b_write", 32'(fifo_write), 32'h1);
    check_val("b_d_in", 32'(fifo_d_in), 32'hA0);
    rst = 1'b1;
    #1;
    check_val("mid_grant", 32'(grant), 32'h0);
    check_val("mid_ack", 32'(ack), 32'h0);
    check_val("mid_write", 32'(fifo_write), 32'h0);
    check_val("mid_busy", 32'(busy), 32'h0);
    check_val("mid_d_in", 32'(fifo_d_in), 32'h0);
    do_reset();

    // Single producer 2: burst of 4, one idle cycle, burst of 2, drop.
    cur_test = "t2";
    for (int k = 0; k < 6; k++) push(2, 8'(8'h10 + k));
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    cyc(4'b0100, 1'b1, 8'h10, 1'b0);
    cyc(4'b0100, 1'b1, 8'h11, 1'b0);
    cyc(4'b0100, 1'b1, 8'h12, 1'b0);
    cyc(4'b0100, 1'b1, 8'h13, 1'b0);
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    cyc(4'b0100, 1'b1, 8'h14, 1'b0);
    cyc(4'b0100, 1'b1, 8'h15, 1'b0);
    cyc(4'b0100, 1'b0, 8'h00, 1'b0);
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    do_reset();

    // All four requesting: order 0,1,2,3,0 with a gap after each burst.
    cur_test = "t3";
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) push(p, 8'((p << 4) | k));
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++)
        cyc(4'(1 << (b % 4)), 1'b1, 8'(((b % 4) << 4) | ((b / 4) * 4 + j)), 1'b0);
      cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    end
    do_reset();

    // Producer 1 stalled by full for 3 cycles after 2 words.
    cur_test = "t4";
    for (int k = 0; k < 6; k++) push(1, 8'(8'h20 + k));
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    cyc(4'b0010, 1'b1, 8'h20, 1'b0);
    cyc(4'b0010, 1'b1, 8'h21, 1'b0);
    cyc(4'b0010, 1'b0, 8'h00, 1'b1);
    cyc(4'b0010, 1'b0, 8'h00, 1'b1);
    cyc(4'b0010, 1'b0, 8'h00, 1'b1);
    cyc(4'b0010, 1'b1, 8'h22, 1'b0);
    cyc(4'b0010, 1'b1, 8'h23, 1'b0);
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    do_reset();

    // Producer 0 drops after one word; producer 3 goes next, then 0 again.
    cur_test = "t5";
    push(0, 8'h01);
    for (int k = 1; k <= 4; k++) push(3, 8'(8'h30 + k));
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    cyc(4'b0001, 1'b1, 8'h01, 1'b0);
    cyc(4'b0001, 1'b0, 8'h00, 1'b0);
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    push(0, 8'h02);
    cyc(4'b1000, 1'b1, 8'h31, 1'b0);
    cyc(4'b1000, 1'b1, 8'h32, 1'b0);
    cyc(4'b1000, 1'b1, 8'h33, 1'b0);
    cyc(4'b1000, 1'b1, 8'h34, 1'b0);
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    cyc(4'b0001, 1'b1, 8'h02, 1'b0);
    cyc(4'b0001, 1'b0, 8'h00, 1'b0);
    cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    do_reset();

    // Twelve words into a depth-8 FIFO model with no reads.
    cur_test = "t6";
    fifo_mode = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++) push(p, 8'(((p + 1) << 4) | (k + 1)));
    exp6 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24};
    for (int c = 0; c < 40; c++) begin
      drive_inputs();
      #1;
      if (fifo_write && fifo_full) viol++;
      advance(fifo_write, ack, fifo_d_in);
    end
    drive_inputs();
    #1;
    check_val("write_when_full", 32'(viol), 32'h0);
    check_val("fifo_count", 32'(fcnt), 32'h8);
    check_val("ack_count", 32'(acnt), 32'h8);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("fifo_word%0d", k), 32'(fmem[k]), 32'(exp6[k]));
      check_val($sformatf("ack_word%0d", k), 32'(alog[k]), 32'(exp6[k]));
    end
    check_val("stall_grant", 32'(grant), 32'h4);
    check_val("stall_write", 32'(fifo_write), 32'h0);
    check_val("stall_ack", 32'(ack), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 8-bit synchronous FIFO between several producers. Each producer presents a word with a request. The arbiter grants one producer at a time for a bounded burst and steers that producer's data onto the FIFO's `d_in`/`write` pins. It obeys the FIFO's `full` flag, so no word is ever lost or dropped.

## Interface
Parameters:
- `N_REQ`, 4, number of producers (2..8)
- `DW`, 8, data width; must match the FIFO data width
- `MAX_BURST`, 4, maximum words per grant (1..15)

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input `N_REQ`: per-producer "word available"; the word is held stable until acked.
- `wdata` input `N_REQ*DW`: producer i's word is in bits [i*DW +: DW].
- `ack` output `N_REQ`: one-hot; the granted producer's word is written this cycle.
- `grant` output `N_REQ`: one-hot current owner; all zero when idle.
- `busy` output 1: high while in BURST.
- `fifo_full` input 1: the FIFO's `full` output.
- `fifo_d_in` output `DW`: drives the FIFO `d_in`.
- `fifo_write` output 1: drives the FIFO `write`.

## Operation
State machine with two states, IDLE and BURST. Registers:
- `state`
- `grant` (one-hot)
- `last` (index of the last owner)
- `bcnt`, width clog2(MAX_BURST+1)

IDLE:
- `grant` = 0 and `fifo_write` = 0.
- If any `req` bit is set, select the first set bit scanning upward from `last`+1 modulo `N_REQ`.
- Register that producer's `grant` bit, load `bcnt` = 0 and go to BURST.

BURST, with g = granted index:
- `fifo_write` = `req[g]` & ~`fifo_full` (combinational).
- `fifo_d_in` = `wdata` slice g at all times in BURST; it is 0 in IDLE.
- `ack[g]` = `fifo_write`; all other `ack` bits are 0.
- On each write, `bcnt` increments.

Burst end:
- The burst ends when a write makes `bcnt` reach `MAX_BURST`, or when `req[g]` is low in any BURST cycle.
- If `req[g]` is already low on the first BURST cycle, the burst ends with zero words written.
- At burst end: `last` ← g, `grant` ← 0, `state` ← IDLE.

`fifo_full` high in BURST:
- No write and no ack.
- `bcnt` holds and the state holds.
- There is no timeout; the owner keeps the grant through the stall.

Other rules:
- Requests from non-granted producers are ignored until re-arbitration; their data is never sampled.
- `busy` = (state == BURST).

Reset:
- All registers clear asynchronously: `state` = IDLE, `grant` = 0, `bcnt` = 0.
- `last` = `N_REQ`-1, so producer 0 has highest priority after reset.
- Outputs `ack` = 0, `fifo_write` = 0, `fifo_d_in` = 0, `busy` = 0.
- Words already written stay in the FIFO; FIFO reset is separate.

## Timing
- Arbitration latency is 1 cycle: `req` rising in IDLE gives `grant` on the next edge. The first write can occur in that same BURST cycle.
- Ack is same-cycle. The producer advances its word on the clock edge where `ack` is high.
- Back-to-back writes in BURST: one word per cycle while `req[g]` and ~`fifo_full`.
- Turnaround: exactly one IDLE cycle between consecutive bursts, including a re-grant to the same producer.
- `fifo_full` is used combinationally in the same cycle, so a FIFO at full never sees `write` high.
- Asserting `rst` mid-burst clears the outputs without waiting for a clock edge. The first grant after release needs one clock in IDLE.

## Structure
Shared package `fifo_arb_pkg` holds:
- the state enum (IDLE, BURST)
- the default `N_REQ`/`DW`/`MAX_BURST` constants
- a clog2 helper function for the `bcnt` width

One sub-module, `rr_pick`:
- Purely combinational rotating-priority picker.
- Inputs: `req` vector and `last` index.
- Outputs: one-hot pick and its index.
- Reusable by later read-side schedulers.

## Test plan
1. Reset: hold `rst`=1 with `req`=1111 → `grant`=0000, `ack`=0000, `fifo_write`=0, `busy`=0. The mid-cycle assertion clears the outputs immediately.
2. Single producer 2 holding `req`, words 0x10..0x15, full=0:
   - `grant`=0100 one cycle after `req`, then writes 0x10..0x13 on 4 consecutive cycles.
   - One IDLE cycle follows, then re-grant and writes 0x14, 0x15.
   - Producer 2 drops `req` → IDLE.
3. All four producers requesting continuously → grant order 0, 1, 2, 3, 0, with 4 writes each and a 1-cycle gap between bursts.
4. Producer 1 granted, `fifo_full`=1 for 3 cycles after 2 words:
   - `fifo_write`=0 and `ack`=0 during the stall; `grant` stays 0010.
   - Then exactly 2 more words are written before the burst ends.
5. Producer 0 drops `req` after 1 word with producers 0 and 3 requesting → burst ends and producer 3 is granted next. Producer 0's later `req` is served after producer 3.
6. Drive `fifo_full` from a real `fifo_8bit` instance:
   - Producers push 12 words with no reads.
   - `write` is never high while `full`=1.
   - The first 8 words in FIFO order match the ack order.
